// File: rtl/move_scheduler.sv
// Turn sequencer between the debounced player buttons and the battleship core.
// Optional shooting-turn timer is built when MOVE_SCHEDULER_TIMEOUT_EN is defined.
module move_scheduler #(
   parameter int SHIPS           = 4,
   parameter int COOLDOWN_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pAb,
   input  logic       pBb,
   input  logic [1:0] X,
   input  logic [1:0] Y,
   input  logic       game_over,
   input  logic       mv_ready,
   output logic       mv_valid,
   output logic       mv_player,
   output logic       mv_kind,
   output logic [1:0] mv_x,
   output logic [1:0] mv_y,
   output logic [2:0] phase,
   output logic       timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_PLACE_A, S_PLACE_B, S_SHOOT_A, S_SHOOT_B, S_ISSUE, S_COOLDOWN, S_DONE
   } state_t;

   localparam logic [2:0] PH_IDLE    = 3'd0;
   localparam logic [2:0] PH_PLACE_A = 3'd1;
   localparam logic [2:0] PH_PLACE_B = 3'd2;
   localparam logic [2:0] PH_SHOOT_A = 3'd3;
   localparam logic [2:0] PH_SHOOT_B = 3'd4;
   localparam logic [2:0] PH_DONE    = 3'd5;

   localparam int             CDW     = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN_CYCLES - 1);
   localparam logic [3:0]     SHIPS_L = 4'(SHIPS);

   if (SHIPS < 1 || SHIPS > 7 || COOLDOWN_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("move_scheduler: parameter out of range");
   end

   state_t         state;
   logic           prev_a, prev_b, prev_s;
   logic [2:0]     place_cnt;
   logic [CDW-1:0] cd_cnt;
   logic           edge_a, edge_b, edge_s;
   logic           act_edge, act_player, is_shoot;
   logic [3:0]     cnt_inc;

   assign edge_a     = pAb & ~prev_a;
   assign edge_b     = pBb & ~prev_b;
   assign edge_s     = start & ~prev_s;
   assign act_player = (state == S_PLACE_B) || (state == S_SHOOT_B);
   assign act_edge   = act_player ? edge_b : edge_a;
   assign is_shoot   = (state == S_SHOOT_A) || (state == S_SHOOT_B);
   assign cnt_inc    = {1'b0, place_cnt} + 4'd1;

`ifdef MOVE_SCHEDULER_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] turn_timer;
`else
   assign timeout = 1'b0;
`endif

   // Handshake: mv_valid rises with a latched payload that stays frozen until the
   // cycle where mv_valid && mv_ready; the move is consumed on that edge exactly once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         prev_a    <= 1'b0;
         prev_b    <= 1'b0;
         prev_s    <= 1'b0;
         place_cnt <= '0;
         cd_cnt    <= '0;
         mv_valid  <= 1'b0;
         mv_player <= 1'b0;
         mv_kind   <= 1'b0;
         mv_x      <= '0;
         mv_y      <= '0;
         phase     <= PH_IDLE;
`ifdef MOVE_SCHEDULER_TIMEOUT_EN
         turn_timer <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         prev_a <= pAb;
         prev_b <= pBb;
         prev_s <= start;
`ifdef MOVE_SCHEDULER_TIMEOUT_EN
         timeout <= 1'b0;
         if (!is_shoot) turn_timer <= '0;
`endif
         case (state)
            S_IDLE, S_DONE: begin
               if (edge_s) begin
                  state     <= S_PLACE_A;
                  phase     <= PH_PLACE_A;
                  place_cnt <= '0;
               end
            end
            S_PLACE_A, S_PLACE_B, S_SHOOT_A, S_SHOOT_B: begin
               if (is_shoot && game_over) begin
                  state <= S_DONE;
                  phase <= PH_DONE;
               end else if (act_edge) begin
                  mv_x      <= X;
                  mv_y      <= Y;
                  mv_player <= act_player;
                  mv_kind   <= is_shoot;
                  mv_valid  <= 1'b1;
                  state     <= S_ISSUE;
               end
`ifdef MOVE_SCHEDULER_TIMEOUT_EN
               else if (is_shoot && turn_timer == TO_LAST) begin
                  state      <= (state == S_SHOOT_A) ? S_SHOOT_B : S_SHOOT_A;
                  phase      <= (state == S_SHOOT_A) ? PH_SHOOT_B : PH_SHOOT_A;
                  timeout    <= 1'b1;
                  turn_timer <= '0;
               end else if (is_shoot) begin
                  turn_timer <= turn_timer + 1'b1;
               end
`endif
            end
            S_ISSUE: begin
               if (mv_ready) begin
                  mv_valid <= 1'b0;
                  cd_cnt   <= '0;
                  state    <= S_COOLDOWN;
               end
            end
            S_COOLDOWN: begin
               // phase still holds the originating phase, so it picks the return state
               if (cd_cnt != CD_LAST) begin
                  cd_cnt <= cd_cnt + 1'b1;
               end else if (game_over) begin
                  state <= S_DONE;
                  phase <= PH_DONE;
               end else if (!mv_kind) begin
                  if (cnt_inc < SHIPS_L) begin
                     place_cnt <= cnt_inc[2:0];
                     state     <= (phase == PH_PLACE_A) ? S_PLACE_A : S_PLACE_B;
                  end else begin
                     place_cnt <= '0;
                     state     <= (phase == PH_PLACE_A) ? S_PLACE_B : S_SHOOT_A;
                     phase     <= (phase == PH_PLACE_A) ? PH_PLACE_B : PH_SHOOT_A;
                  end
               end else begin
                  state <= (phase == PH_SHOOT_A) ? S_SHOOT_B : S_SHOOT_A;
                  phase <= (phase == PH_SHOOT_A) ? PH_SHOOT_B : PH_SHOOT_A;
               end
            end
            default: begin
               state <= S_IDLE;
               phase <= PH_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// Table-driven bench for move_scheduler (SHIPS=2, COOLDOWN_CYCLES=2, TIMEOUT_CYCLES=8).
// Timer expectations follow MOVE_SCHEDULER_TIMEOUT_EN as seen by this file.
module tb_move_scheduler;

`ifdef MOVE_SCHEDULER_TIMEOUT_EN
   localparam int TO_ON = 1;
`else
   localparam int TO_ON = 0;
`endif
   localparam int PH_AFTER = TO_ON ? 3 : 4;
   localparam int PL_AFTER = TO_ON ? 0 : 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, pAb, pBb, game_over, mv_ready;
   logic [1:0] X, Y;
   logic       mv_valid, mv_player, mv_kind, timeout;
   logic [1:0] mv_x, mv_y;
   logic [2:0] phase;

   move_scheduler #(.SHIPS(2), .COOLDOWN_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .start(start), .pAb(pAb), .pBb(pBb), .X(X), .Y(Y),
      .game_over(game_over), .mv_ready(mv_ready), .mv_valid(mv_valid),
      .mv_player(mv_player), .mv_kind(mv_kind), .mv_x(mv_x), .mv_y(mv_y),
      .phase(phase), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       st, a, b;
      logic [1:0] x, y;
      logic       rdy, go;
      logic       e_v, e_pl, e_k;
      logic [1:0] e_x, e_y;
      logic [2:0] e_ph;
      logic       e_to, pay;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] exp_q[$];
   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         row_idx = -1;

   task automatic chk(input string nm, input int got, input int exp);
      total_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s (row %0d): got %0d, expected %0d", nm, row_idx, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int st, input int a, input int b, input int x, input int y,
                      input int rdy, input int go, input int v, input int pl, input int k,
                      input int ex, input int ey, input int ph, input int to, input int pay);
      vec_t r;
      r.st = 1'(st); r.a = 1'(a); r.b = 1'(b); r.x = 2'(x); r.y = 2'(y);
      r.rdy = 1'(rdy); r.go = 1'(go); r.e_v = 1'(v); r.e_pl = 1'(pl); r.e_k = 1'(k);
      r.e_x = 2'(ex); r.e_y = 2'(ey); r.e_ph = 3'(ph); r.e_to = 1'(to); r.pay = 1'(pay);
      vecs.push_back(r);
   endtask

   task automatic idle(input int n, input int ph);
      for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ph, 0, 0);
   endtask

   // Scoreboard: every accepted move must match the next expected payload.
   always @(negedge clk) begin
      if (rst === 1'b1 && mv_valid && mv_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_move", int'({mv_player, mv_kind, mv_x, mv_y}), -1);
         end else begin
            chk("accepted_move", int'({mv_player, mv_kind, mv_x, mv_y}), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b0; start = 0; pAb = 0; pBb = 0; X = 0; Y = 0; game_over = 0; mv_ready = 0;

      // reset, held pAb, start
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // placement A: (2,1) then (0,3), payload frozen while X/Y move
      add(0, 1, 0, 2, 1, 1, 0, 1, 0, 0, 2, 1, 1, 0, 1);
      add(0, 1, 0, 3, 3, 1, 0, 0, 0, 0, 2, 1, 1, 0, 1);
      idle(2, 1);
      add(0, 1, 0, 0, 3, 1, 0, 1, 0, 0, 0, 3, 1, 0, 1);
      add(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 1, 0, 1);
      idle(1, 1);
      idle(1, 2);
      // placement B, A edge ignored
      add(0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      add(0, 0, 1, 1, 2, 1, 0, 1, 1, 0, 1, 2, 2, 0, 1);
      idle(3, 2);
      add(0, 0, 1, 3, 0, 1, 0, 1, 1, 0, 3, 0, 2, 0, 1);
      idle(2, 2);
      idle(1, 3);
      // handshake stall in SHOOT_A
      add(0, 1, 0, 2, 2, 0, 0, 1, 0, 1, 2, 2, 3, 0, 1);
      for (int i = 0; i < 6; i++) add(0, 0, (i % 2 == 0) ? 1 : 0, i, 5 - i, 0, 0, 1, 0, 1, 2, 2, 3, 0, 1);
      add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 2, 2, 3, 0, 1);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);
      idle(1, 4);
      // simultaneous press in SHOOT_B
      add(0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 4, 0, 1);
      idle(2, 4);
      idle(1, 3);
      // press on the expiry cycle of SHOOT_A
      idle(7, 3);
      add(0, 1, 0, 0, 2, 1, 0, 1, 0, 1, 0, 2, 3, 0, 1);
      idle(2, 3);
      idle(1, 4);
      // no press in SHOOT_B: forfeit
      idle(7, 4);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, PH_AFTER, TO_ON, 0);
      idle(1, PH_AFTER);
      // game over raised during cooldown
      add(0, 1, 1, 3, 3, 1, 0, 1, PL_AFTER, 1, 3, 3, PH_AFTER, 0, 1);
      idle(1, PH_AFTER);
      add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, PH_AFTER, 0, 0);
      add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0);
      add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0);
      add(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      // restart: counter cleared, two placements needed
      add(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1);
      idle(3, 1);
      add(0, 1, 0, 2, 3, 1, 0, 1, 0, 0, 2, 3, 1, 0, 1);
      idle(2, 1);
      idle(1, 2);
      // start and game_over ignored while placing
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
      idle(1, 2);

      repeat (3) tick();
      chk("rst_valid", int'(mv_valid), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_player", int'(mv_player), 0);
      chk("rst_kind", int'(mv_kind), 0);
      chk("rst_x", int'(mv_x), 0);
      chk("rst_y", int'(mv_y), 0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         row_idx = i;
         start = vecs[i].st; pAb = vecs[i].a; pBb = vecs[i].b; X = vecs[i].x; Y = vecs[i].y;
         mv_ready = vecs[i].rdy; game_over = vecs[i].go;
         if (vecs[i].pay && vecs[i].e_v && (i == 0 || !vecs[i-1].e_v))
            exp_q.push_back({vecs[i].e_pl, vecs[i].e_k, vecs[i].e_x, vecs[i].e_y});
         tick();
         chk("valid", int'(mv_valid), int'(vecs[i].e_v));
         chk("phase", int'(phase), int'(vecs[i].e_ph));
         chk("timeout", int'(timeout), int'(vecs[i].e_to));
         if (vecs[i].pay) begin
            chk("player", int'(mv_player), int'(vecs[i].e_pl));
            chk("kind", int'(mv_kind), int'(vecs[i].e_k));
            chk("x", int'(mv_x), int'(vecs[i].e_x));
            chk("y", int'(mv_y), int'(vecs[i].e_y));
         end
      end

      // asynchronous reset while a move is pending
      row_idx = -2;
      start = 0; pAb = 0; game_over = 0; mv_ready = 0; pBb = 1; X = 2; Y = 1;
      tick();
      chk("pend_valid", int'(mv_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk("async_valid", int'(mv_valid), 0);
      chk("async_phase", int'(phase), 0);
      chk("async_x", int'(mv_x), 0);
      @(posedge clk);
      #1 rst = 1'b1; pBb = 0;
      tick();
      chk("post_rst_phase", int'(phase), 0);
      start = 1;
      tick();
      chk("post_rst_start", int'(phase), 1);
      start = 0;
      tick();

      chk("moves_left", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
